axi_read_responder: RTL and testbench
=====================================

# axi_read_responder

Synthesizable AXI read-channel responder (AR in, R out) that models the DDR side of the prefetcher's master read port. Accepts read bursts on an AR slave interface, queues them in order, and returns each burst on the R channel after a programmable fixed latency, with an address-derived data pattern so benches can check returned data without a backing RAM. Replaces the behavioural RAM in trace-replay benches that need controllable, repeatable read latency.

## Interface

Parameters:
- ADDR_BITS, 16: AR address width.
- TID_WIDTH, 8: AR/R ID width.
- BURST_LEN_WIDTH, 8: AR len width; burst = len+1 beats.
- LOG_BLOCK_DATA_BYTES, 0: beat size = 2^N bytes; DATA_WIDTH = 8·2^N.
- LOG_QUEUE_SIZE, 3: outstanding-request queue depth = 2^N.
- LATENCY_WIDTH, 8: width of crs_latency and per-entry countdown.

Ports:
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- s_ar_valid  in  1  AR request valid.
- s_ar_ready  out  1  AR request accepted when high with valid.
- s_ar_addr  in  ADDR_BITS  burst start byte address.
- s_ar_len  in  BURST_LEN_WIDTH  beats minus one.
- s_ar_id  in  TID_WIDTH  transaction ID.
- m_r_valid  out  1  R beat valid.
- m_r_ready  in  1  R beat consumed.
- m_r_data  out  DATA_WIDTH  beat data.
- m_r_id  out  TID_WIDTH  ID of current burst.
- m_r_last  out  1  final beat of burst.
- crs_latency  in  LATENCY_WIDTH  response latency L in cycles, sampled per request.
- occupancy  out  LOG_QUEUE_SIZE+1  entries currently queued (including burst in progress).

## Operation

- Queue: circular FIFO of 2^LOG_QUEUE_SIZE entries {addr, len, id, countdown}; head = oldest. Responses strictly in acceptance order, no ID reordering.
- Accept: s_ar_ready = (occupancy != 2^LOG_QUEUE_SIZE), combinational from registered occupancy; also 0 while resetN low. Handshake writes entry at tail with countdown = crs_latency.
- Countdown: every entry with countdown>0 decrements by 1 each clock edge; saturates at 0. Later crs_latency changes affect only newly accepted requests.
- R state machine: IDLE -> BURST when head exists and head countdown==0 (beat index loaded 0). BURST: m_r_valid=1; on handshake, beat index +1; on handshake with m_r_last, pop head; go to BURST for next entry if it is present and eligible in the same cycle (zero-bubble), else IDLE.
- Data: m_r_data = (addr + beat·2^LOG_BLOCK_DATA_BYTES) modulo 2^ADDR_BITS, zero-extended or truncated (low bits kept) to DATA_WIDTH. m_r_id = head id; m_r_last = (beat == head len).
- AXI rules: once m_r_valid high, valid/data/id/last held stable until m_r_ready; valid never drops without handshake.
- Simultaneous push and pop: occupancy unchanged; when full, ready stays 0 that cycle even if a pop occurs (pop frees slot next cycle).
- Address wrap: beat address wraps modulo 2^ADDR_BITS; no 4 KB boundary checking.

## Timing

- Reset (async assert, sync release): queue empty, occupancy=0, s_ar_ready=0, m_r_valid=0, m_r_last=0, m_r_data=0, m_r_id=0, state IDLE. First s_ar_ready=1 in first cycle after resetN high. Reset mid-burst discards all queued requests and in-flight beats.
- Latency: AR handshake at edge T with L=crs_latency, queue otherwise empty -> first beat valid in cycle following edge T+L (L=0: valid right after T, one-cycle minimum).
- Throughput: with m_r_ready held high, one beat per cycle, back-to-back bursts with no idle cycle when next head already eligible.
- Queue-behind-head: a younger entry's countdown runs concurrently; it starts immediately after older burst's last beat if already 0.
- Backpressure: m_r_ready low freezes beat index and outputs; countdowns keep running.

## Test plan

- Single read: L=4, AR addr=0x0EEF len=0 id=5 -> exactly one beat, m_r_valid first high 4 cycles after handshake cycle+1, data=0xEF, id=5, last=1; occupancy 1 -> 0.
- Burst: L=0, addr=0x00FE len=3 id=6 (8-bit data) -> beats 0xFE,0xFF,0x00,0x01 consecutive, last only on 4th.
- Full queue: hold m_r_ready=0, issue 9 ARs len=0 -> 8 accepted, s_ar_ready=0 on 9th; release ready -> 8 beats in order of IDs, then 9th accepted.
- Backpressure stability: len=2, toggle m_r_ready every cycle -> data/id/last stable while valid&!ready, 3 beats total, no duplicates.
- Latency change: accept id=1 with L=10, then id=2 with L=0 -> id=1 returned first after 10 cycles, id=2 immediately after with zero bubble.
- Reset mid-burst: deassert resetN during beat 2 of a len=7 burst -> all outputs 0 asynchronously, occupancy 0, no further beats after release.

Source files
------------

// File: rtl/axi_read_responder.sv
// AXI read responder: queues AR bursts in order and replays each on R after a
// per-request latency, with beat data derived from the beat address.
module axi_read_responder #(
    parameter int ADDR_BITS            = 16,
    parameter int TID_WIDTH            = 8,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int LOG_QUEUE_SIZE       = 3,
    parameter int LATENCY_WIDTH        = 8
) (
    input  logic                                   clk,
    input  logic                                   resetN,
    input  logic                                   s_ar_valid,
    output logic                                   s_ar_ready,
    input  logic [ADDR_BITS-1:0]                   s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]             s_ar_len,
    input  logic [TID_WIDTH-1:0]                   s_ar_id,
    output logic                                   m_r_valid,
    input  logic                                   m_r_ready,
    output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]   m_r_data,
    output logic [TID_WIDTH-1:0]                   m_r_id,
    output logic                                   m_r_last,
    input  logic [LATENCY_WIDTH-1:0]               crs_latency,
    output logic [LOG_QUEUE_SIZE:0]                occupancy
);
    localparam int DATA_W = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int DEPTH  = 1 << LOG_QUEUE_SIZE;
    localparam logic [LOG_QUEUE_SIZE:0] OCC_FULL = (LOG_QUEUE_SIZE+1)'(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                       state_q, state_d;
    logic [BURST_LEN_WIDTH-1:0]   beat_q, beat_d;
    logic [LOG_QUEUE_SIZE-1:0]    head_q, head_d, tail_q, tail_d;
    logic [LOG_QUEUE_SIZE:0]      occ_q, occ_d;
    logic [LATENCY_WIDTH-1:0]     cnt_q [DEPTH];
    logic [LATENCY_WIDTH-1:0]     cnt_d [DEPTH];

    logic [ADDR_BITS-1:0]         addr_mem [DEPTH];
    logic [BURST_LEN_WIDTH-1:0]   len_mem  [DEPTH];
    logic [TID_WIDTH-1:0]         id_mem   [DEPTH];

    logic                         push, pop, beat_hs, busy, last_beat;
    logic [ADDR_BITS-1:0]         beat_addr;

    assign s_ar_ready = resetN && (occ_q != OCC_FULL);
    assign push       = s_ar_valid && s_ar_ready;
    assign busy       = (state_q == BURST);
    assign last_beat  = (beat_q == len_mem[head_q]);
    assign beat_hs    = busy && m_r_ready;
    assign pop        = beat_hs && last_beat;

    // Beat address wraps within the AR address space; DATA_W cast keeps low bits.
    assign beat_addr  = addr_mem[head_q] + (ADDR_BITS'(beat_q) << LOG_BLOCK_DATA_BYTES);

    assign m_r_valid  = busy;
    assign m_r_data   = busy ? DATA_W'(beat_addr) : '0;
    assign m_r_id     = busy ? id_mem[head_q] : '0;
    assign m_r_last   = busy && last_beat;
    assign occupancy  = occ_q;

    always_comb begin
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        head_d  = pop ? head_q + 1'b1 : head_q;
        occ_d   = occ_q;
        state_d = state_q;
        beat_d  = beat_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (tail_q == LOG_QUEUE_SIZE'(i)))
                cnt_d[i] = crs_latency;
            else if (cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - 1'b1;
            else
                cnt_d[i] = cnt_q[i];
        end
        // Eligibility looks at next-cycle head so a ready entry starts without a bubble.
        case (state_q)
            IDLE: begin
                if ((occ_d != '0) && (cnt_d[head_d] == '0)) begin
                    state_d = BURST;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (beat_hs) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ((occ_d != '0) && (cnt_d[head_d] == '0)) ? BURST : IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            beat_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_q] <= s_ar_addr;
            len_mem[tail_q]  <= s_ar_len;
            id_mem[tail_q]   <= s_ar_id;
        end
    end
endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: table of single bursts plus
// hand-written full-queue, backpressure, latency-change and reset sequences.
module tb_axi_read_responder;
    logic        clk = 1'b0;
    logic        resetN;
    logic        s_ar_valid;
    logic        s_ar_ready;
    logic [15:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic [7:0]  s_ar_id;
    logic        m_r_valid;
    logic        m_r_ready;
    logic [7:0]  m_r_data;
    logic [7:0]  m_r_id;
    logic        m_r_last;
    logic [7:0]  crs_latency;
    logic [3:0]  occupancy;

    int n_vec  = 0;
    int n_fail = 0;

    axi_read_responder dut (
        .clk(clk), .resetN(resetN),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
        .m_r_id(m_r_id), .m_r_last(m_r_last),
        .crs_latency(crs_latency), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [7:0]  lat;
        logic [31:0] beats;   // beat k expected data in bits [8k+7:8k]
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one AR and hold it until handshake; returns with the sample point after the handshake edge.
    task automatic send_ar(input logic [15:0] a, input logic [7:0] l, input logic [7:0] id,
                           input logic [7:0] lat);
        int w;
        w = 0;
        while (!s_ar_ready && w < 40) begin
            tick();
            w++;
        end
        chk("ar_ready_wait", {31'd0, s_ar_ready}, 32'd1);
        s_ar_valid  = 1'b1;
        s_ar_addr   = a;
        s_ar_len    = l;
        s_ar_id     = id;
        crs_latency = lat;
        tick();
        s_ar_valid  = 1'b0;
    endtask

    initial begin
        int n, beats, acc_done;
        logic held;
        logic [7:0] hd, hi;
        logic hl;

        vecs[0] = '{addr: 16'h0EEF, len: 8'd0, id: 8'h05, lat: 8'd4, beats: 32'h000000EF};
        vecs[1] = '{addr: 16'h00FE, len: 8'd3, id: 8'h06, lat: 8'd0, beats: 32'h0100FFFE};
        vecs[2] = '{addr: 16'hFFFE, len: 8'd2, id: 8'h07, lat: 8'd1, beats: 32'h0000FFFE};
        vecs[3] = '{addr: 16'h1234, len: 8'd1, id: 8'hAB, lat: 8'd2, beats: 32'h00003534};
        vecs[4] = '{addr: 16'h0080, len: 8'd0, id: 8'hFF, lat: 8'd7, beats: 32'h00000080};

        resetN = 1'b0; s_ar_valid = 1'b0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
        m_r_ready = 1'b1; crs_latency = '0;
        #12;
        chk("rst_ar_ready", {31'd0, s_ar_ready}, 32'd0);
        chk("rst_r_valid", {31'd0, m_r_valid}, 32'd0);
        chk("rst_r_last", {31'd0, m_r_last}, 32'd0);
        chk("rst_r_data", {24'd0, m_r_data}, 32'd0);
        chk("rst_r_id", {24'd0, m_r_id}, 32'd0);
        chk("rst_occ", {28'd0, occupancy}, 32'd0);
        #8 resetN = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, s_ar_ready}, 32'd1);
        $display("reset: checked idle outputs and first ready");

        // Table-driven single bursts, m_r_ready held high.
        for (int v = 0; v < 5; v++) begin
            m_r_ready = 1'b1;
            send_ar(vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].lat);
            chk("occ_after_ar", {28'd0, occupancy}, 32'd1);
            n = 0;
            while (!m_r_valid && n < 40) begin
                tick();
                n++;
            end
            chk("latency", n, {24'd0, vecs[v].lat});
            for (int b = 0; b <= int'(vecs[v].len); b++) begin
                chk("beat_valid", {31'd0, m_r_valid}, 32'd1);
                chk("beat_data", {24'd0, m_r_data}, {24'd0, vecs[v].beats[8*b +: 8]});
                chk("beat_id", {24'd0, m_r_id}, {24'd0, vecs[v].id});
                chk("beat_last", {31'd0, m_r_last}, {31'd0, b == int'(vecs[v].len)});
                tick();
            end
            chk("end_valid", {31'd0, m_r_valid}, 32'd0);
            chk("end_occ", {28'd0, occupancy}, 32'd0);
            $display("vec %0d: addr=%04h len=%0d id=%02h lat=%0d first beat after %0d cycles",
                     v, vecs[v].addr, vecs[v].len, vecs[v].id, vecs[v].lat, n);
        end

        // Full queue: 8 accepted while R is stalled, 9th waits for a pop.
        m_r_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_ar(16'h0100 + 16'(i), 8'd0, 8'h10 + 8'(i), 8'd0);
        chk("full_occ", {28'd0, occupancy}, 32'd8);
        chk("full_ready", {31'd0, s_ar_ready}, 32'd0);
        s_ar_valid = 1'b1; s_ar_addr = 16'h0108; s_ar_len = 8'd0; s_ar_id = 8'h18;
        m_r_ready = 1'b1;
        acc_done = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 0) chk("full_ready_pop_cycle", {31'd0, s_ar_ready}, 32'd0);
            chk("full_valid", {31'd0, m_r_valid}, 32'd1);
            chk("full_id", {24'd0, m_r_id}, 32'h10 + k);
            chk("full_data", {24'd0, m_r_data}, k);
            chk("full_last", {31'd0, m_r_last}, 32'd1);
            n = (s_ar_valid && s_ar_ready) ? 1 : 0;
            tick();
            if (n == 1) begin
                s_ar_valid = 1'b0;
                acc_done = 1;
            end
        end
        chk("full_9th_accepted", acc_done, 1);
        chk("full_end_valid", {31'd0, m_r_valid}, 32'd0);
        chk("full_end_occ", {28'd0, occupancy}, 32'd0);
        $display("full queue: 9 requests returned in id order");

        // Backpressure: m_r_ready toggles, outputs must hold while stalled.
        m_r_ready = 1'b0;
        send_ar(16'h0040, 8'd2, 8'h09, 8'd0);
        beats = 0; held = 1'b0; hd = '0; hi = '0; hl = 1'b0;
        for (int c = 0; c < 12; c++) begin
            m_r_ready = (c % 2 == 1);
            if (held) begin
                chk("bp_hold_valid", {31'd0, m_r_valid}, 32'd1);
                chk("bp_hold_data", {24'd0, m_r_data}, {24'd0, hd});
                chk("bp_hold_id", {24'd0, m_r_id}, {24'd0, hi});
                chk("bp_hold_last", {31'd0, m_r_last}, {31'd0, hl});
            end
            if (m_r_valid && m_r_ready) begin
                chk("bp_data", {24'd0, m_r_data}, 32'h40 + beats);
                chk("bp_id", {24'd0, m_r_id}, 32'h09);
                chk("bp_last", {31'd0, m_r_last}, {31'd0, beats == 2});
                beats++;
            end
            held = m_r_valid && !m_r_ready;
            hd = m_r_data; hi = m_r_id; hl = m_r_last;
            tick();
        end
        chk("bp_beat_count", beats, 3);
        chk("bp_end_valid", {31'd0, m_r_valid}, 32'd0);
        $display("backpressure: %0d beats delivered", beats);

        // Latency change: long-latency head, zero-latency follower, no bubble.
        m_r_ready = 1'b1;
        send_ar(16'h0211, 8'd0, 8'h01, 8'd10);
        s_ar_valid = 1'b1; s_ar_addr = 16'h0322; s_ar_len = 8'd0; s_ar_id = 8'h02; crs_latency = 8'd0;
        tick();
        s_ar_valid = 1'b0;
        chk("lat_occ", {28'd0, occupancy}, 32'd2);
        n = 1;
        while (!m_r_valid && n < 40) begin
            tick();
            n++;
        end
        chk("lat_first", n, 10);
        chk("lat_id1", {24'd0, m_r_id}, 32'h01);
        chk("lat_data1", {24'd0, m_r_data}, 32'h11);
        tick();
        chk("lat_valid2", {31'd0, m_r_valid}, 32'd1);
        chk("lat_id2", {24'd0, m_r_id}, 32'h02);
        chk("lat_data2", {24'd0, m_r_data}, 32'h22);
        tick();
        chk("lat_end_valid", {31'd0, m_r_valid}, 32'd0);
        $display("latency change: id1 after %0d cycles, id2 back-to-back", n);

        // Reset during beat 2 of an 8-beat burst.
        send_ar(16'h0500, 8'd7, 8'h03, 8'd0);
        tick();
        tick();
        chk("rb_beat2", {24'd0, m_r_data}, 32'h02);
        #2 resetN = 1'b0;
        #1;
        chk("rb_valid", {31'd0, m_r_valid}, 32'd0);
        chk("rb_data", {24'd0, m_r_data}, 32'd0);
        chk("rb_id", {24'd0, m_r_id}, 32'd0);
        chk("rb_last", {31'd0, m_r_last}, 32'd0);
        chk("rb_occ", {28'd0, occupancy}, 32'd0);
        chk("rb_ready", {31'd0, s_ar_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_r_valid) n++;
        end
        chk("rb_no_beats", n, 0);
        chk("rb_occ_after", {28'd0, occupancy}, 32'd0);
        $display("reset mid-burst: %0d beats after release", n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
